// File: rtl/alu_stage.sv
// Accumulator ALU stage: single-cycle EXEC ops plus an 8-edge shift-add multiplier.
// Define ALU_STAGE_MUL_EN to build the MUL datapath; without it opcode 111 is a NOP.
module alu_stage (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [7:0] operand,
    input  logic [7:0] acc_in,
    output logic [7:0] result,
    output logic       acc_update,
    output logic       busy,
    output logic       done,
    output logic       carry,
    output logic       zero
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL1 = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

`ifdef ALU_STAGE_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t     state_q, state_d;
    logic       accept;

    logic [2:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       upd_q;

    logic [7:0] result_q;
    logic       carry_q;
    logic       zero_q;

    logic [7:0] alu_res;
    logic       alu_carry;

`ifdef ALU_STAGE_MUL_EN
    logic [15:0] prod_q;
    logic [2:0]  cnt_q;
    logic [15:0] mul_sum;

    // Partial product for the multiplier bit currently in b_q[0].
    always_comb begin
        mul_sum = prod_q;
        if (b_q[0]) begin
            mul_sum = prod_q + ({8'h00, a_q} << cnt_q);
        end
    end
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    accept  = 1'b1;
                    state_d = EXEC;
`ifdef ALU_STAGE_MUL_EN
                    if (opcode == OP_MUL) begin
                        state_d = MUL;
                    end
`endif
                end
            end
            EXEC: state_d = DONE;
`ifdef ALU_STAGE_MUL_EN
            MUL: begin
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle operations on the latched operands; 111 falls through as a NOP.
    always_comb begin
        alu_res   = 8'h00;
        alu_carry = 1'b0;
        case (op_q)
            OP_PASS: alu_res = b_q;
            OP_ADD:  {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: begin
                alu_res   = a_q - b_q;
                alu_carry = (a_q < b_q);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SHL1: begin
                alu_res   = {a_q[6:0], 1'b0};
                alu_carry = a_q[7];
            end
            default: alu_res = a_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q     <= 3'b000;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            upd_q    <= 1'b0;
            result_q <= 8'h00;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ALU_STAGE_MUL_EN
            prod_q   <= 16'h0000;
            cnt_q    <= 3'd0;
`endif
        end else begin
            if (accept) begin
                op_q <= opcode;
                a_q  <= acc_in;
                b_q  <= operand;
`ifdef ALU_STAGE_MUL_EN
                prod_q <= 16'h0000;
                cnt_q  <= 3'd0;
`endif
            end

            if (state_q == EXEC) begin
                result_q <= alu_res;
                carry_q  <= alu_carry;
                zero_q   <= (alu_res == 8'h00);
                // Only the NOP form of opcode 111 ever reaches EXEC; it must not write back.
                upd_q    <= (op_q != OP_MUL);
            end

`ifdef ALU_STAGE_MUL_EN
            if (state_q == MUL) begin
                prod_q <= mul_sum;
                b_q    <= {1'b0, b_q[7:1]};
                cnt_q  <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    result_q <= mul_sum[7:0];
                    carry_q  <= (mul_sum[15:8] != 8'h00);
                    zero_q   <= (mul_sum[7:0] == 8'h00);
                    upd_q    <= 1'b1;
                end
            end
`endif
        end
    end

`ifdef ALU_STAGE_MUL_EN
    assign busy = (state_q == EXEC) || (state_q == MUL);
`else
    assign busy = (state_q == EXEC);
`endif
    assign done       = (state_q == DONE);
    assign acc_update = (state_q == DONE) && upd_q;
    assign result     = result_q;
    assign carry      = carry_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_alu_stage.sv
// Scoreboard bench for alu_stage: random ops against an arithmetic reference model.
// Follows the ALU_STAGE_MUL_EN setting of the build for opcode 111.
module tb_alu_stage;

`ifdef ALU_STAGE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [7:0] operand = 8'h00;
    logic [7:0] acc_in = 8'h00;
    logic [7:0] result;
    logic       acc_update, busy, done, carry, zero;

    alu_stage dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .operand    (operand),
        .acc_in     (acc_in),
        .result     (result),
        .acc_update (acc_update),
        .busy       (busy),
        .done       (done),
        .carry      (carry),
        .zero       (zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       u;
    } want_t;

    want_t q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model from the arithmetic definition of each opcode.
    function automatic want_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        want_t w;
        int    ia, ib, v;
        ia  = a;
        ib  = b;
        w.c = 1'b0;
        w.u = 1'b1;
        case (op)
            3'd0: v = ib;
            3'd1: begin v = ia + ib; w.c = (v > 255); end
            3'd2: begin v = ia - ib; w.c = (ia < ib); if (v < 0) v += 256; end
            3'd3: v = ia & ib;
            3'd4: v = ia | ib;
            3'd5: v = ia ^ ib;
            3'd6: begin v = ia * 2; w.c = (v > 255); end
            default: begin
                if (MUL_EN) begin
                    v = ia * ib;
                    w.c = (v > 255);
                end else begin
                    v = ia;
                    w.u = 1'b0;
                end
            end
        endcase
        w.r = 8'(v % 256);
        w.z = (w.r == 8'h00);
        return w;
    endfunction

    // Monitor: every done pulse retires the oldest expected completion.
    always @(negedge clock) begin
        if (!reset && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no completion pending");
            end else begin
                want_t w;
                w = q.pop_front();
                check("result", {8'h00, result}, {8'h00, w.r});
                check("carry", {15'h0, carry}, {15'h0, w.c});
                check("zero", {15'h0, zero}, {15'h0, w.z});
                check("acc_update", {15'h0, acc_update}, {15'h0, w.u});
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit poke);
        want_t w;
        int    edges, busy_cycles, lat;
        w   = model(op, a, b);
        lat = (MUL_EN && op == 3'd7) ? 9 : 2;
        @(negedge clock);
        start   = 1'b1;
        opcode  = op;
        acc_in  = a;
        operand = b;
        q.push_back(w);
        @(posedge clock);
        #1;
        start   = 1'b0;
        opcode  = 3'($urandom);
        acc_in  = 8'($urandom);
        operand = 8'($urandom);
        edges = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && edges < 20) begin
            if (busy) busy_cycles++;
            if (poke) begin
                start   = 1'($urandom_range(0, 1));
                opcode  = 3'($urandom);
                acc_in  = 8'($urandom);
                operand = 8'($urandom);
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            edges++;
        end
        check("done_seen", {15'h0, done}, 16'h1);
        check("latency", 16'(edges), 16'(lat));
        check("busy_cycles", 16'(busy_cycles), 16'(lat - 1));
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check("hold_result", {8'h00, result}, {8'h00, w.r});
        check("hold_carry", {15'h0, carry}, {15'h0, w.c});
        check("idle_done_low", {15'h0, done}, 16'h0);
    endtask

    task automatic back_to_back(input logic [7:0] a1, input logic [7:0] b1,
                                input logic [7:0] a2, input logic [7:0] b2);
        @(negedge clock);
        start   = 1'b1;
        opcode  = 3'd1;
        acc_in  = a1;
        operand = b1;
        q.push_back(model(3'd1, a1, b1));
        @(posedge clock);
        #1;
        opcode  = 3'd5;
        acc_in  = a2;
        operand = b2;
        q.push_back(model(3'd5, a2, b2));
        @(posedge clock);
        #1;
        check("b2b_done1", {15'h0, done}, 16'h1);
        @(posedge clock);
        #1;
        start = 1'b0;
        check("b2b_gap_done", {15'h0, done}, 16'h0);
        check("b2b_second_busy", {15'h0, busy}, 16'h1);
        @(posedge clock);
        #1;
        check("b2b_done2", {15'h0, done}, 16'h1);
        @(posedge clock);
        #1;
        check("b2b_done_once", {15'h0, done}, 16'h0);
    endtask

    task automatic reset_mid_op();
        @(negedge clock);
        start   = 1'b1;
        opcode  = MUL_EN ? 3'd7 : 3'd1;
        acc_in  = 8'h37;
        operand = 8'h59;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (MUL_EN) begin
            repeat (4) @(posedge clock);
            #1;
        end
        check("pre_reset_busy", {15'h0, busy}, 16'h1);
        reset = 1'b1;
        #1;
        check("rst_result", {8'h00, result}, 16'h0);
        check("rst_flags", {14'h0, carry, zero}, 16'h0);
        check("rst_strobes", {13'h0, busy, done, acc_update}, 16'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            check("post_reset_quiet", {14'h0, done, busy}, 16'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        #3;
        check("reset_result", {8'h00, result}, 16'h0);
        check("reset_flags", {14'h0, carry, zero}, 16'h0);
        check("reset_strobes", {13'h0, busy, done, acc_update}, 16'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        run_op(3'd1, 8'hF0, 8'h20, 1'b0);
        run_op(3'd2, 8'h05, 8'h05, 1'b0);
        run_op(3'd2, 8'h03, 8'h04, 1'b1);
        run_op(3'd6, 8'hC3, 8'h00, 1'b1);
        if (MUL_EN) run_op(3'd7, 8'h10, 8'h11, 1'b1);
        else        run_op(3'd7, 8'h5A, 8'h99, 1'b1);
        run_op(3'd7, 8'hFF, 8'hFF, 1'b0);
        run_op(3'd0, 8'h12, 8'h00, 1'b0);

        back_to_back(8'h81, 8'h7F, 8'h3C, 8'hA5);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        reset_mid_op();
        run_op(3'd1, 8'h22, 8'h33, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        check("queue_drained", 16'(q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_stage.md
ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be fixed at 8 bits.
REQ-002 clock  input  1  clock; all state SHALL update on the posedge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin one operation; sampled on the clock posedge.
REQ-005 opcode  input  3  operation select: 000 PASS, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 SHL1, 111 MUL.
REQ-006 operand  input  8  B operand, taken from memory or an immediate.
REQ-007 acc_in  input  8  A operand, the current accumulator value.
REQ-008 result  output  8  registered result; drives the accumulator data input.
REQ-009 acc_update  output  1  one-cycle strobe; drives the accumulator update input.
REQ-010 busy  output  1  high while an accepted operation is in progress.
REQ-011 done  output  1  one-cycle completion strobe, coincident with acc_update.
REQ-012 carry  output  1  registered carry/borrow/overflow flag.
REQ-013 zero  output  1  registered flag, high when result == 0.

Function
REQ-014 The FSM SHALL have the states IDLE, EXEC, MUL and DONE.
REQ-015 In IDLE or DONE, start=1 at a posedge SHALL be accepted:
- opcode, operand and acc_in latched.
- next state EXEC, or MUL for a MUL opcode.
REQ-016 start SHALL be ignored while busy=1, with no queuing.
REQ-017 busy SHALL be high in EXEC and MUL and low in IDLE and DONE.
REQ-018 EXEC SHALL compute for one edge, register result and flags, then enter DONE.
- Latency from accepting edge to done visible: 2 edges.
REQ-019 In DONE, done=1 and acc_update=1 for exactly one cycle.
- Next state IDLE, or EXEC/MUL if start=1 (back-to-back issue).
REQ-020 ADD: result = A+B mod 256; carry = bit 8 of the 9-bit sum.
REQ-021 SUB: result = A-B mod 256; carry = 1 when A < B (borrow).
REQ-022 AND, OR, XOR and PASS (result = B): carry = 0.
REQ-023 SHL1: result = {A[6:0],0}; carry = A[7].
REQ-024 MUL: unsigned shift-add, one multiplier bit per edge, 8 edges in MUL, then DONE.
- result = product[7:0]; carry = 1 when product[15:8] != 0.
REQ-025 zero SHALL be registered together with result on every completion.
REQ-026 result, carry and zero SHALL hold their values between completions.
REQ-027 Input changes after the accepting edge SHALL NOT affect the operation in progress.

Reset
REQ-028 Reset asserted SHALL immediately force:
- state IDLE
- result=0x00, carry=0, zero=0
- busy=0, done=0, acc_update=0
- MUL counter and internal registers = 0.
REQ-029 Reset mid-operation SHALL discard the operation, with no done or acc_update pulse afterward.
REQ-030 After reset deasserts, the first posedge with start=1 SHALL be accepted normally.

Configuration
REQ-031 Macro ALU_STAGE_MUL_EN SHALL control the MUL datapath.
- Defined: MUL datapath, the MUL state and the 3-bit counter compiled in; opcode 111 behaves per REQ-024.
- Undefined: all of these omitted; opcode 111 is a NOP that takes the EXEC path with 2-edge latency.
- NOP result: result = acc_in, carry = 0, zero per result.
- NOP strobes: done=1, acc_update=0.

Verification
REQ-032 Reset mid-MUL: issue MUL, assert reset on the 4th MUL edge -> all outputs 0 immediately, no done afterward, next ADD completes normally.
REQ-033 ADD 0xF0+0x20 -> result=0x10, carry=1, zero=0; done and acc_update high for one cycle, 2 edges after the accepting edge.
REQ-034 SUB 0x05-0x05 -> result=0x00, zero=1, carry=0. SUB 0x03-0x04 -> result=0xFF, carry=1.
REQ-035 MUL_EN defined, MUL 0x10*0x11 -> result=0x10, carry=1, busy high for exactly 8 cycles, done 9 edges after acceptance.
REQ-036 MUL_EN undefined, opcode 111 with acc_in=0x5A -> result=0x5A, done=1, acc_update=0.
REQ-037 Back-to-back: start held high, issue ADD then XOR -> second op accepted in the DONE cycle, two done pulses 2 cycles apart.
- start pulses during busy -> ignored.
